// File: rtl/uvmt_cv32e40s_obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// uvmt_cv32e40s_obi_mem_arbiter
//
// Shares one OBI memory slave port between the core's instruction-fetch
// and data OBI master ports.
//
// Arbitration
//   - Round-robin between the two ports.
//   - Once an address phase is shown to memory without a grant, it is
//     locked in place until the handshake completes.
//
// Responses
//   - Responses are in order.
//   - They are routed back through a small FIFO that records the source
//     of every granted request.
//   - A response with nothing outstanding raises a sticky protocol error.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   instr_req_i/gnt_o/addr_i  instruction address phase (read-only)
//   instr_rvalid/rdata/err_o  instruction response phase
//   data_req/we/addr/be/wdata data address phase, data_gnt_o grant
//   data_rvalid/rdata/err_o   data response phase
//   mem_req/we/addr/be/wdata  shared memory address phase (out)
//   mem_gnt/rvalid/rdata/err  shared memory grant and response (in)
//   protocol_err_o            sticky: response seen with no outstanding txn
// ---------------------------------------------------------------------------
module uvmt_cv32e40s_obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i,

    output logic                    protocol_err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // The arbiter is open until a request is shown without a grant.
    // It then holds that request until the handshake completes.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e             state_reg, state_next;
    src_e                   lock_src_reg, lock_src_next;
    src_e                   last_src_reg, last_src_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic                   protocol_err_reg, protocol_err_next;

    src_e                   fifo_mem [MAX_OUTSTANDING];
    src_e                   head_src;

    src_e                   sel;
    logic                   sel_req;
    logic                   room;
    logic                   handshake;
    logic                   pop;
    logic                   stray_rsp;

    // -----------------------------------------------------------------------
    // Source selection
    // -----------------------------------------------------------------------
    // When both ports request, the one not served last wins. The same rule
    // also applies when neither requests, so that the address mux is
    // always driven from a defined source.
    always_comb begin
        sel = SRC_INSTR;
        if (state_reg == ST_LOCKED) begin
            sel = lock_src_reg;
        end else if (instr_req_i && !data_req_i) begin
            sel = SRC_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel = SRC_DATA;
        end else begin
            sel = (last_src_reg == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end
    end

    assign sel_req = (sel == SRC_DATA) ? data_req_i : instr_req_i;

    // A response in the current cycle frees a slot at the same clock edge
    // that a new grant would fill one. The memory may therefore be offered
    // a request while the FIFO is full, provided a pop is happening.
    // The head is read before the new entry overwrites that slot.
    assign pop       = mem_rvalid_i && (count_reg != '0);
    assign stray_rsp = mem_rvalid_i && (count_reg == '0);
    assign room      = (count_reg != FULL_COUNT) || pop;

    assign mem_req_o   = sel_req && room;
    assign handshake   = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = handshake && (sel == SRC_INSTR);
    assign data_gnt_o  = handshake && (sel == SRC_DATA);

    // -----------------------------------------------------------------------
    // Address-phase mux
    // -----------------------------------------------------------------------
    // The instruction port is read-only, so it presents a full-word read.
    assign mem_we_o   = (sel == SRC_DATA) ? data_we_i : 1'b0;
    assign mem_addr_o = (sel == SRC_DATA) ? data_addr_i : instr_addr_i;

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign mem_be_o[gi]          = (sel == SRC_DATA) ? data_be_i[gi] : 1'b1;
            assign mem_wdata_o[gi*8 +: 8] = (sel == SRC_DATA) ? data_wdata_i[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    assign head_src = fifo_mem[rd_ptr_reg];

    assign instr_rvalid_o = pop && (head_src == SRC_INSTR);
    assign data_rvalid_o  = pop && (head_src == SRC_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o  && mem_err_i;

    assign protocol_err_o = protocol_err_reg;

    // -----------------------------------------------------------------------
    // Lock FSM and bookkeeping: next-state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        lock_src_next     = lock_src_reg;
        last_src_next     = last_src_reg;
        count_next        = count_reg;
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        protocol_err_next = protocol_err_reg;

        case (state_reg)
            ST_OPEN: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_next    = ST_LOCKED;
                    lock_src_next = sel;
                end
            end
            ST_LOCKED: begin
                if (handshake) begin
                    state_next = ST_OPEN;
                end
            end
            default: begin
                state_next = ST_OPEN;
            end
        endcase

        if (handshake) begin
            last_src_next = sel;
            wr_ptr_next   = wr_ptr_reg + 1'b1;
        end

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case ({handshake, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (stray_rsp) begin
            protocol_err_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // last_src resets to data, so the instruction port wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= ST_OPEN;
            lock_src_reg     <= SRC_INSTR;
            last_src_reg     <= SRC_DATA;
            count_reg        <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            lock_src_reg     <= lock_src_next;
            last_src_reg     <= last_src_next;
            count_reg        <= count_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            protocol_err_reg <= protocol_err_next;
        end
    end

    // FIFO storage. It needs no reset: an entry is only read after it has
    // been written, and a reset also clears the pointers and the count.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_mem[wr_ptr_reg] <= sel;
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_mem_arbiter.sv
module tb_uvmt_cv32e40s_obi_mem_arbiter;

    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DADDR = 32'h0000_2000;
    localparam logic [3:0]  DBE   = 4'b0110;
    localparam logic [31:0] DWDAT = 32'hDA7A_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uvmt_cv32e40s_obi_mem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_gnt_o     (data_gnt),
        .data_addr_i    (data_addr),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_be_o       (mem_be),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err),
        .protocol_err_o (protocol_err)
    );

    // in = {instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err}
    // ex = {mem_req, sel, instr_gnt, data_gnt, instr_rvalid, data_rvalid,
    //       instr_err, data_err, protocol_err}
    // erd = rdata expected on whichever port has rvalid (other port 0)
    typedef struct packed {
        logic [5:0]  in;
        logic [31:0] rd;
        logic [8:0]  ex;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rd,
                                input logic [8:0] ex, input logic [31:0] erd);
        vec_t v;
        v.in  = in;
        v.rd  = rd;
        v.ex  = ex;
        v.erd = erd;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw,
                         input logic g, input logic rv, input logic e,
                         input logic [31:0] rd);
        instr_req  = ir;
        data_req   = dr;
        data_we    = dw;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_err    = e;
        mem_rdata  = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ------------------------------------------------------------ table
        // Round-robin with continuous dual requests, response 1 cycle later
        vecs.push_back(mk(6'b110100, 32'h0,         9'b101000000, 32'h0));         // 0
        vecs.push_back(mk(6'b110110, 32'hA1A1_0001, 9'b110110000, 32'hA1A1_0001)); // 1
        vecs.push_back(mk(6'b110110, 32'hA1A1_0002, 9'b101001000, 32'hA1A1_0002)); // 2
        vecs.push_back(mk(6'b000110, 32'hA1A1_0003, 9'b000010000, 32'hA1A1_0003)); // 3
        // Data write stalled 3 cycles, instr joins in cycle 2: lock holds data
        vecs.push_back(mk(6'b011000, 32'h0,         9'b110000000, 32'h0));         // 4
        vecs.push_back(mk(6'b111000, 32'h0,         9'b110000000, 32'h0));         // 5
        vecs.push_back(mk(6'b111000, 32'h0,         9'b110000000, 32'h0));         // 6
        vecs.push_back(mk(6'b111100, 32'h0,         9'b110100000, 32'h0));         // 7
        vecs.push_back(mk(6'b100110, 32'hB0B0_0001, 9'b101001000, 32'hB0B0_0001)); // 8
        vecs.push_back(mk(6'b000010, 32'hB0B0_0002, 9'b000010000, 32'hB0B0_0002)); // 9
        // Four instr grants with responses withheld, then full
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 10
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 11
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 12
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 13
        vecs.push_back(mk(6'b100100, 32'h0,         9'b000000000, 32'h0));         // 14 full
        vecs.push_back(mk(6'b100110, 32'hC0C0_0001, 9'b101010000, 32'hC0C0_0001)); // 15 pop frees
        vecs.push_back(mk(6'b000010, 32'hC0C0_0002, 9'b000010000, 32'hC0C0_0002)); // 16
        vecs.push_back(mk(6'b000010, 32'hC0C0_0003, 9'b000010000, 32'hC0C0_0003)); // 17
        vecs.push_back(mk(6'b000010, 32'hC0C0_0004, 9'b000010000, 32'hC0C0_0004)); // 18
        vecs.push_back(mk(6'b000010, 32'hC0C0_0005, 9'b000010000, 32'hC0C0_0005)); // 19
        // I, D, D, I outstanding; error on the 2nd response
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 20
        vecs.push_back(mk(6'b010100, 32'h0,         9'b110100000, 32'h0));         // 21
        vecs.push_back(mk(6'b010100, 32'h0,         9'b110100000, 32'h0));         // 22
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000000, 32'h0));         // 23
        vecs.push_back(mk(6'b000010, 32'hD0D0_0001, 9'b000010000, 32'hD0D0_0001)); // 24
        vecs.push_back(mk(6'b000011, 32'hD0D0_0002, 9'b000001010, 32'hD0D0_0002)); // 25
        vecs.push_back(mk(6'b000010, 32'hD0D0_0003, 9'b000001000, 32'hD0D0_0003)); // 26
        vecs.push_back(mk(6'b000010, 32'hD0D0_0004, 9'b000010000, 32'hD0D0_0004)); // 27
        // Stray response at count 0, then sticky error
        vecs.push_back(mk(6'b000010, 32'hE0E0_0001, 9'b000000000, 32'h0));         // 28
        vecs.push_back(mk(6'b000000, 32'h0,         9'b000000001, 32'h0));         // 29
        vecs.push_back(mk(6'b100100, 32'h0,         9'b101000001, 32'h0));         // 30
        vecs.push_back(mk(6'b000010, 32'hE0E0_0002, 9'b000010001, 32'hE0E0_0002)); // 31

        // ------------------------------------------------------------ reset
        instr_addr = IADDR;
        data_addr  = DADDR;
        data_be    = DBE;
        data_wdata = DWDAT;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        chk1("reset mem_req",      mem_req,      1'b0);
        chk1("reset instr_gnt",    instr_gnt,    1'b0);
        chk1("reset data_gnt",     data_gnt,     1'b0);
        chk1("reset instr_rvalid", instr_rvalid, 1'b0);
        chk1("reset data_rvalid",  data_rvalid,  1'b0);
        chk1("reset protocol_err", protocol_err, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // ------------------------------------------------------- vector loop
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] exp_addr, exp_wdata;
            logic [3:0]  exp_be;
            logic        exp_we;
            v = vecs[i];
            drive(v.in[5], v.in[4], v.in[3], v.in[2], v.in[1], v.in[0], v.rd);
            #3;
            $display("vec %0d: in=%b rdata=%h expect=%b mem_req=%b gnt=%b%b rvalid=%b%b perr=%b",
                     i, v.in, v.rd, v.ex, mem_req, instr_gnt, data_gnt,
                     instr_rvalid, data_rvalid, protocol_err);
            chk1($sformatf("v%0d mem_req", i),      mem_req,      v.ex[8]);
            chk1($sformatf("v%0d instr_gnt", i),    instr_gnt,    v.ex[6]);
            chk1($sformatf("v%0d data_gnt", i),     data_gnt,     v.ex[5]);
            chk1($sformatf("v%0d instr_rvalid", i), instr_rvalid, v.ex[4]);
            chk1($sformatf("v%0d data_rvalid", i),  data_rvalid,  v.ex[3]);
            chk1($sformatf("v%0d instr_err", i),    instr_err,    v.ex[2]);
            chk1($sformatf("v%0d data_err", i),     data_err,     v.ex[1]);
            chk1($sformatf("v%0d protocol_err", i), protocol_err, v.ex[0]);
            chk32($sformatf("v%0d instr_rdata", i), instr_rdata, v.ex[4] ? v.erd : 32'h0);
            chk32($sformatf("v%0d data_rdata", i),  data_rdata,  v.ex[3] ? v.erd : 32'h0);
            if (v.ex[8]) begin
                exp_addr  = v.ex[7] ? DADDR : IADDR;
                exp_we    = v.ex[7] ? v.in[3] : 1'b0;
                exp_be    = v.ex[7] ? DBE : 4'hF;
                exp_wdata = v.ex[7] ? DWDAT : 32'h0;
                chk32($sformatf("v%0d mem_addr", i),  mem_addr,  exp_addr);
                chk1($sformatf("v%0d mem_we", i),     mem_we,    exp_we);
                chk32($sformatf("v%0d mem_be", i),    {28'h0, mem_be}, {28'h0, exp_be});
                chk32($sformatf("v%0d mem_wdata", i), mem_wdata, exp_wdata);
            end
            next_cycle();
        end

        // ------------------------------------ reset with 3 outstanding (hand)
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            #3;
            $display("hand fill %0d: instr_gnt=%b", k, instr_gnt);
            chk1($sformatf("fill%0d instr_gnt", k), instr_gnt, 1'b1);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #3;
        $display("hand reset: mem_req=%b perr=%b", mem_req, protocol_err);
        chk1("midrst protocol_err", protocol_err, 1'b0);
        chk1("midrst mem_req",      mem_req,      1'b0);
        chk1("midrst instr_gnt",    instr_gnt,    1'b0);
        chk1("midrst instr_rvalid", instr_rvalid, 1'b0);
        next_cycle();
        rst = 1'b0;

        // first tie after reset goes to instr
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #3;
        $display("hand post-reset tie: gnt=%b%b addr=%h", instr_gnt, data_gnt, mem_addr);
        chk1("postrst instr_gnt", instr_gnt, 1'b1);
        chk1("postrst data_gnt",  data_gnt,  1'b0);
        chk32("postrst mem_addr", mem_addr,  IADDR);
        next_cycle();

        // response to the single post-reset grant
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF0F0_0001);
        #3;
        $display("hand post-reset rsp1: rvalid=%b%b rdata=%h", instr_rvalid, data_rvalid, instr_rdata);
        chk1("postrst rsp1 instr_rvalid", instr_rvalid, 1'b1);
        chk32("postrst rsp1 instr_rdata", instr_rdata,  32'hF0F0_0001);
        chk1("postrst rsp1 protocol_err", protocol_err, 1'b0);
        next_cycle();

        // stale entries must be gone: this response is a stray
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF0F0_0002);
        #3;
        $display("hand post-reset rsp2: rvalid=%b%b", instr_rvalid, data_rvalid);
        chk1("postrst rsp2 instr_rvalid", instr_rvalid, 1'b0);
        chk1("postrst rsp2 data_rvalid",  data_rvalid,  1'b0);
        next_cycle();

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        $display("hand post-reset idle: perr=%b", protocol_err);
        chk1("postrst protocol_err", protocol_err, 1'b1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
